vram_arbiter: RTL and testbench

- Owns the single-port synchronous video RAM that holds the character buffer and shares it between three requesters.
- Requesters: the character-mode PPU fetch (real-time, highest priority), the 6502 bus interface (read/write), and a built-in clear-screen engine that fills the buffer with a blank character.
- Sits between the CPU address decoder, the PPU character fetch and the VRAM macro.
- Replaces the PPU's direct combinational array read.

---
 rtl/vram_arbiter.sv | 123 ++++++++++++
 tb/tb_vram_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port character-buffer VRAM between PPU fetch, CPU bus and clear engine
// Ports:
//   clk, rst_n                      system clock, asynchronous active-low reset
//   ppu_req/ppu_addr                single-cycle PPU fetch request (highest priority, never queued)
//   ppu_data/ppu_valid/ppu_miss     fetched character two cycles after request; miss pulse when preempted
//   cpu_req/cpu_we/cpu_addr/wdata   CPU access held until cpu_ack (combinational grant)
//   cpu_rdata/cpu_rvalid            CPU read data two cycles after the granted request
//   clr_start/clr_busy              start pulse and busy flag of the clear-screen engine
//   mem_addr/mem_we/mem_wdata       registered VRAM port; mem_rdata is captured at the end of the access cycle
module vram_arbiter #(
  parameter int AW = 12,
  parameter int DW = 8,
  parameter int BUFFSIZE = 2368,
  parameter logic [DW-1:0] CLR_CHAR = 8'h20,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ppu_req,
  input  logic [AW-1:0] ppu_addr,
  output logic [DW-1:0] ppu_data,
  output logic          ppu_valid,
  output logic          ppu_miss,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);
  localparam logic [AW-1:0] LAST = AW'(BUFFSIZE - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  // read in flight during the access cycle: owner and whether it was out of range
  logic ppu_rd_q, ppu_rd_d, cpu_rd_q, cpu_rd_d, oor_q, oor_d;
  logic ppu_miss_q, ppu_miss_d;
  logic ppu_valid_q, ppu_valid_d, cpu_rvalid_q, cpu_rvalid_d;
  logic [DW-1:0] ppu_data_q, ppu_data_d, cpu_rdata_q, cpu_rdata_d;
  logic cpu_force, gnt_cpu, gnt_ppu, gnt_clr, cpu_oor, ppu_oor, clr_last;
  logic [DW-1:0] rd_val;
  always_comb begin
    cpu_force = cpu_req && (wait_cnt_q == WMAX);
    gnt_cpu = cpu_req && (cpu_force || !ppu_req);
    gnt_ppu = ppu_req && !cpu_force;
    gnt_clr = (state_q == CLEAR) && !ppu_req && !cpu_req;
    cpu_oor = 32'(cpu_addr) >= BUFFSIZE;
    ppu_oor = 32'(ppu_addr) >= BUFFSIZE;
    clr_last = clr_ptr_q == LAST;
    // out-of-range accesses still consume the slot but never assert the write strobe
    mem_addr_d = gnt_cpu ? cpu_addr : gnt_ppu ? ppu_addr : gnt_clr ? clr_ptr_q : mem_addr_q;
    mem_we_d = gnt_cpu ? (cpu_we && !cpu_oor) : gnt_clr;
    mem_wdata_d = gnt_cpu ? cpu_wdata : gnt_clr ? CLR_CHAR : mem_wdata_q;
    ppu_rd_d = gnt_ppu;
    cpu_rd_d = gnt_cpu && !cpu_we;
    oor_d = gnt_cpu ? cpu_oor : ppu_oor;
    ppu_miss_d = ppu_req && cpu_force;
    rd_val = oor_q ? CLR_CHAR : mem_rdata;
    ppu_valid_d = ppu_rd_q;
    ppu_data_d = ppu_rd_q ? rd_val : ppu_data_q;
    cpu_rvalid_d = cpu_rd_q;
    cpu_rdata_d = cpu_rd_q ? rd_val : cpu_rdata_q;
    wait_cnt_d = (!cpu_req || gnt_cpu) ? '0 : (wait_cnt_q == WMAX) ? WMAX : wait_cnt_q + 1'b1;
    state_d = (state_q == IDLE) ? (clr_start ? CLEAR : IDLE) : (gnt_clr && clr_last) ? IDLE : CLEAR;
    clr_ptr_d = (state_q == IDLE) ? '0 : gnt_clr ? (clr_last ? '0 : clr_ptr_q + 1'b1) : clr_ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      clr_ptr_q <= '0;
      wait_cnt_q <= '0;
      mem_addr_q <= '0;
      mem_we_q <= 1'b0;
      mem_wdata_q <= '0;
      ppu_rd_q <= 1'b0;
      cpu_rd_q <= 1'b0;
      oor_q <= 1'b0;
      ppu_miss_q <= 1'b0;
      ppu_valid_q <= 1'b0;
      ppu_data_q <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      ppu_rd_q <= ppu_rd_d;
      cpu_rd_q <= cpu_rd_d;
      oor_q <= oor_d;
      ppu_miss_q <= ppu_miss_d;
      ppu_valid_q <= ppu_valid_d;
      ppu_data_q <= ppu_data_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end
  assign cpu_ack = gnt_cpu && rst_n;
  assign clr_busy = state_q == CLEAR;
  assign mem_addr = mem_addr_q;
  assign mem_we = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign ppu_miss = ppu_miss_q;
  assign ppu_valid = ppu_valid_q;
  assign ppu_data = ppu_data_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata = cpu_rdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural VRAM model
module tb_vram_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int BUFFSIZE = 2368;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ppu_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, clr_start = 1'b0;
  logic [AW-1:0] ppu_addr = '0, cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] ppu_data, cpu_rdata, mem_wdata, mem_rdata;
  logic ppu_valid, ppu_miss, cpu_ack, cpu_rvalid, clr_busy, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int checks = 0, errors = 0, cyc = 0;
  int miss_cnt = 0, miss_cyc = 0, busy_tot = 0, wr_oor = 0;
  logic [DW-1:0] ppu_q[$], cpu_q[$];
  int ppu_cq[$], cpu_cq[$];
  vram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_data(ppu_data), .ppu_valid(ppu_valid), .ppu_miss(ppu_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ppu_miss) begin
      miss_cnt++;
      miss_cyc = cyc;
    end
    if (clr_busy) busy_tot++;
    if (mem_we && 32'(mem_addr) >= BUFFSIZE) wr_oor++;
    if (ppu_valid) begin
      check("ppu_pending", ppu_q.size() > 0, 1);
      if (ppu_q.size() > 0) begin
        check("ppu_data", ppu_data, ppu_q.pop_front());
        check("ppu_latency", cyc, ppu_cq.pop_front() + 2);
      end
    end
    if (cpu_rvalid) begin
      check("cpu_pending", cpu_q.size() > 0, 1);
      if (cpu_q.size() > 0) begin
        check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
        check("cpu_latency", cyc, cpu_cq.pop_front() + 2);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ppu_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
    ppu_req = 1'b1;
    ppu_addr = a;
    ppu_q.push_back(e);
    ppu_cq.push_back(cyc);
    tick();
    ppu_req = 1'b0;
  endtask
  task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] e);
    int n = 0;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    @(negedge clk);
    while (!cpu_ack && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cpu_ack", cpu_ack, 1);
    if (cpu_ack && !we) begin
      cpu_q.push_back(e);
      cpu_cq.push_back(cyc);
    end
    tick();
    cpu_req = 1'b0;
  endtask
  initial begin
    int gi, ack_cyc, m0, b0;
    #2 rst_n = 1'b0;
    cpu_req = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ppu_valid", ppu_valid, 0);
    check("rst_ppu_miss", ppu_miss, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_clr_busy", clr_busy, 0);
    cpu_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    cpu_op(1'b1, 12'd5, 8'h41, 8'h00);
    ppu_read(12'd5, 8'h41);
    @(negedge clk);
    check("ppu_mem_addr", mem_addr, 5);
    check("ppu_mem_we", mem_we, 0);
    check("ppu_no_miss", ppu_miss, 0);
    repeat (3) tick();
    cpu_op(1'b1, 12'd100, 8'h7E, 8'h00);
    @(negedge clk);
    check("cpu_wr_we", mem_we, 1);
    check("cpu_wr_addr", mem_addr, 100);
    check("cpu_wr_data", mem_wdata, 8'h7E);
    tick();
    cpu_op(1'b0, 12'd100, 8'h00, 8'h7E);
    repeat (3) tick();
    gi = -1;
    ack_cyc = 0;
    m0 = miss_cnt;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 12'd100;
    for (int i = 0; i < 8; i++) begin
      ppu_req = 1'b1;
      ppu_addr = 12'd5;
      @(negedge clk);
      if (cpu_req && cpu_ack) begin
        gi = i;
        ack_cyc = cyc;
        cpu_q.push_back(8'h7E);
        cpu_cq.push_back(cyc);
      end else begin
        ppu_q.push_back(8'h41);
        ppu_cq.push_back(cyc);
      end
      tick();
      if (gi >= 0) cpu_req = 1'b0;
    end
    ppu_req = 1'b0;
    repeat (4) tick();
    check("starve_grant_idx", gi, 4);
    check("starve_miss_count", miss_cnt - m0, 1);
    check("starve_miss_cycle", miss_cyc, ack_cyc + 1);
    cpu_op(1'b1, 12'd3000, 8'h99, 8'h00);
    @(negedge clk);
    check("oor_wr_we", mem_we, 0);
    tick();
    ppu_read(12'd2400, 8'h20);
    cpu_op(1'b0, 12'd4000, 8'h00, 8'h20);
    repeat (4) tick();
    b0 = busy_tot;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    @(negedge clk);
    check("clr_busy_start", clr_busy, 1);
    repeat (2400) tick();
    check("clr_length", busy_tot - b0, BUFFSIZE);
    check("clr_done", clr_busy, 0);
    for (int a = 0; a < BUFFSIZE; a++) ppu_read(12'(a), 8'h20);
    repeat (4) tick();
    b0 = busy_tot;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    cpu_op(1'b1, 12'd2367, 8'h33, 8'h00);
    for (int k = 0; k < 9; k++) cpu_op(1'b1, 12'(2000 + k), 8'(k + 1), 8'h00);
    repeat (20) tick();
    cpu_op(1'b1, 12'd3, 8'h5A, 8'h00);
    repeat (2500) tick();
    check("clr_interleave_len", busy_tot - b0, BUFFSIZE + 11);
    ppu_read(12'd2367, 8'h20);
    ppu_read(12'd2004, 8'h20);
    ppu_read(12'd3, 8'h5A);
    repeat (4) tick();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (50) tick();
    check("abort_pre_busy", clr_busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", clr_busy, 0);
    check("abort_we", mem_we, 0);
    tick();
    rst_n = 1'b1;
    tick();
    cpu_op(1'b1, 12'd0, 8'h99, 8'h00);
    cpu_op(1'b1, 12'd1, 8'h99, 8'h00);
    tick();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    @(negedge clk);
    check("restart_addr", mem_addr, 0);
    check("restart_we", mem_we, 1);
    check("restart_data", mem_wdata, 8'h20);
    repeat (2400) tick();
    check("restart_done", clr_busy, 0);
    ppu_read(12'd0, 8'h20);
    ppu_read(12'd1, 8'h20);
    repeat (4) tick();
    check("oor_writes", wr_oor, 0);
    check("scoreboard_empty", ppu_q.size() + cpu_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
